// File: rtl/cpu_lsu_pkg.sv
// cpu_lsu_pkg: size encodings, FSM state codes and the size helper shared by the load/store unit
package cpu_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RADDR   = 3'd1;
    localparam state_t ST_RWAIT   = 3'd2;
    localparam state_t ST_RSAMPLE = 3'd3;
    localparam state_t ST_WSETUP  = 3'd4;
    localparam state_t ST_WSTROBE = 3'd5;
    localparam state_t ST_DONE    = 3'd6;

    function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/cpu_lsu_extend.sv
// lsu_extend: zero- or sign-extends a right-aligned N-byte load result to the full data width
module lsu_extend
    import cpu_lsu_pkg::*;
#(
    parameter int DATA_BYTES = 4
) (
    input  logic [8*DATA_BYTES-1:0] acc,
    input  logic [1:0]              size,
    input  logic                    sign_en,
    output logic [8*DATA_BYTES-1:0] rdata
);

    logic [3:0] n;
    logic       fill;

    assign n = size_to_bytes(size);

    // take the sign from the top loaded byte, then overwrite every byte above it
    always_comb begin
        fill  = 1'b0;
        rdata = acc;
        for (int b = 0; b < DATA_BYTES; b++) if (4'(b + 1) == n) fill = sign_en & acc[8*b+7];
        for (int b = 0; b < DATA_BYTES; b++) if (4'(b) >= n) rdata[8*b +: 8] = {8{fill}};
    end

endmodule

// File: rtl/cpu_lsu.sv
// cpu_lsu: byte-serial big-endian load/store unit; define CPU_LSU_ALIGN_CHECK_EN to fault misaligned requests
module cpu_lsu
    import cpu_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_BYTES   = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    rsp_error,
    output logic [ADDR_WIDTH-1:0]   mem_raddr,
    output logic [ADDR_WIDTH-1:0]   mem_waddr,
    output logic [7:0]              mem_data_in,
    output logic                    mem_write,
    input  logic [7:0]              mem_data_out,
    input  logic                    mem_ready
);

    localparam int         DW       = 8 * DATA_BYTES;
    localparam logic [3:0] DB       = 4'(DATA_BYTES);
    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_raddr_q, mem_raddr_d, mem_waddr_q, mem_waddr_d;
    logic [DW-1:0]         wdata_q, wdata_d, acc_q, acc_d, rsp_rdata_q, rsp_rdata_d, ext_rdata;
    logic [1:0]            size_q, size_d, lat_q, lat_d;
    logic [3:0]            k_q, k_d, k_inc, n_q, req_n;
    logic [7:0]            mem_data_in_q, mem_data_in_d;
    logic                  write_q, write_d, signed_q, signed_d, err_q, err_d, clr_q, clr_d;
    logic                  mem_write_q, mem_write_d, rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic                  size_bad, misalign;

    assign req_n    = size_to_bytes(req_size);
    assign n_q      = size_to_bytes(size_q);
    assign k_inc    = k_q + 4'd1;
    assign size_bad = req_n > DB;
`ifdef CPU_LSU_ALIGN_CHECK_EN
    assign misalign = |(req_addr & ADDR_WIDTH'(req_n - 4'd1));
`else
    assign misalign = 1'b0;
`endif

    assign req_ready   = state_q == ST_IDLE;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign mem_raddr   = mem_raddr_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_write   = mem_write_q;

    lsu_extend #(.DATA_BYTES(DATA_BYTES)) u_extend (
        .acc     (acc_q),
        .size    (size_q),
        .sign_en (signed_q),
        .rdata   (ext_rdata)
    );

    // sequencing FSM: one byte per RADDR/RSAMPLE or WSETUP/WSTROBE pair, k counts bytes done
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        write_d       = write_q;
        signed_d      = signed_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        clr_d         = clr_q;
        k_d           = k_q;
        lat_d         = lat_q;
        acc_d         = acc_q;
        mem_raddr_d   = mem_raddr_q;
        mem_waddr_d   = mem_waddr_q;
        mem_data_in_d = mem_data_in_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                addr_d   = req_addr;
                size_d   = req_size;
                write_d  = req_write;
                signed_d = req_signed;
                wdata_d  = req_wdata;
                err_d    = size_bad | misalign;
                clr_d    = misalign;
                k_d      = '0;
                acc_d    = '0;
                state_d  = (size_bad || misalign) ? ST_DONE : req_write ? ST_WSETUP : ST_RADDR;
            end
            ST_RADDR: begin
                mem_raddr_d = addr_q + ADDR_WIDTH'(k_q);
                lat_d       = LAT_INIT;
                if (mem_ready) state_d = (READ_LATENCY == 1) ? ST_RSAMPLE : ST_RWAIT;
            end
            ST_RWAIT: begin
                lat_d = lat_q - 2'd1;
                if (lat_q == 2'd0) state_d = ST_RSAMPLE;
            end
            ST_RSAMPLE: begin
                acc_d   = (acc_q << 8) | DW'(mem_data_out);
                k_d     = k_inc;
                state_d = (k_inc < n_q) ? ST_RADDR : ST_DONE;
            end
            ST_WSETUP: begin
                mem_waddr_d   = addr_q + ADDR_WIDTH'(k_q);
                mem_data_in_d = 8'(wdata_q >> {n_q - k_inc, 3'b000});
                if (mem_ready) state_d = ST_WSTROBE;
            end
            ST_WSTROBE: begin
                k_d     = k_inc;
                state_d = (k_inc < n_q) ? ST_WSETUP : ST_DONE;
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                rsp_error_d = err_q;
                rsp_rdata_d = clr_q ? '0 : (write_q || err_q) ? rsp_rdata_q : ext_rdata;
            end
            default: state_d = ST_IDLE;
        endcase
        mem_write_d = state_d == ST_WSTROBE;
        rsp_valid_d = state_q == ST_DONE;
    end

    // state and output registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            size_q        <= '0;
            write_q       <= 1'b0;
            signed_q      <= 1'b0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            clr_q         <= 1'b0;
            k_q           <= '0;
            lat_q         <= '0;
            acc_q         <= '0;
            mem_raddr_q   <= '0;
            mem_waddr_q   <= '0;
            mem_data_in_q <= '0;
            mem_write_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            write_q       <= write_d;
            signed_q      <= signed_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            clr_q         <= clr_d;
            k_q           <= k_d;
            lat_q         <= lat_d;
            acc_q         <= acc_d;
            mem_raddr_q   <= mem_raddr_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_write_q   <= mem_write_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
        end
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// tb_cpu_lsu: directed bench for cpu_lsu (ADDR_WIDTH=9, DATA_BYTES=4, READ_LATENCY=2) with a one-stage RAM model
module tb_cpu_lsu;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, mem_ready = 1'b1;
    logic [1:0]  req_size = 2'd0;
    logic [8:0]  req_addr = 9'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_error, mem_write;
    logic [31:0] rsp_rdata;
    logic [8:0]  mem_raddr, mem_waddr;
    logic [7:0]  mem_data_in, mem_data_out;

    logic [7:0]  mem [0:511];
    logic [7:0]  rd_q = 8'd0;
    logic        poke_en = 1'b0;
    logic [8:0]  poke_addr = 9'd0;
    logic [7:0]  poke_data = 8'd0;
    logic [8:0]  wl_a [0:63];
    logic [7:0]  wl_d [0:63];
    logic [8:0]  rl [0:63];
    logic [5:0]  wcnt = 6'd0, rcnt = 6'd0;
    logic [8:0]  raddr_prev = 9'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign mem_data_out = rd_q;

    cpu_lsu #(.ADDR_WIDTH(9), .DATA_BYTES(4), .READ_LATENCY(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .mem_raddr    (mem_raddr),
        .mem_waddr    (mem_waddr),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready)
    );

    // RAM with one register stage (data sampled two cycles after mem_raddr is registered), plus access logs
    always @(posedge clk) begin
        rd_q <= mem[mem_raddr];
        if (mem_write) begin
            mem[mem_waddr] <= mem_data_in;
            wl_a[wcnt]     <= mem_waddr;
            wl_d[wcnt]     <= mem_data_in;
            wcnt           <= wcnt + 6'd1;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
        if (mem_raddr != raddr_prev) begin
            rl[rcnt] <= mem_raddr;
            rcnt     <= rcnt + 6'd1;
        end
        raddr_prev <= mem_raddr;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [8:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    // issue one request, return cycles from accept edge to rsp_valid (-1 on timeout)
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg, input logic [8:0] a,
                           input logic [31:0] wd, input bit stall, output int lat);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = !stall;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            mem_ready = !stall || (n % 8 >= 5);
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, seen;
        logic [5:0]  wb, rb;
        logic [7:0]  sb [4];
        logic [31:0] last_rdata;
        logic [8:0]  last_raddr;
        sb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        repeat (2) @(posedge clk); #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_error", 64'(rsp_error), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_raddr", 64'(mem_raddr), 64'd0);
        check("rst_mem_waddr", 64'(mem_waddr), 64'd0);
        check("rst_mem_din", 64'(mem_data_in), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        poke(9'h010, 8'h12); poke(9'h011, 8'h34); poke(9'h012, 8'h56); poke(9'h013, 8'h78);
        run_req(1'b0, 2'd2, 1'b0, 9'h010, 32'd0, 1'b0, lat);
        check("ldw_lat", 64'(lat), 64'd13);
        check("ldw_data", 64'(rsp_rdata), 64'h12345678);
        check("ldw_err", 64'(rsp_error), 64'd0);

        wb = wcnt;
        run_req(1'b1, 2'd2, 1'b0, 9'h020, 32'hDEADBEEF, 1'b0, lat);
        check("stw_lat", 64'(lat), 64'd9);
        check("stw_err", 64'(rsp_error), 64'd0);
        check("stw_nwr", 64'(6'(wcnt - wb)), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stw_addr%0d", i), 64'(wl_a[6'(wb + 6'(i))]), 64'(9'h020 + 9'(i)));
            check($sformatf("stw_data%0d", i), 64'(wl_d[6'(wb + 6'(i))]), 64'(sb[i]));
        end
        check("stw_rdata_held", 64'(rsp_rdata), 64'h12345678);
        run_req(1'b0, 2'd2, 1'b0, 9'h020, 32'd0, 1'b0, lat);
        check("ldw_back", 64'(rsp_rdata), 64'hDEADBEEF);

        poke(9'h030, 8'h80);
        run_req(1'b0, 2'd0, 1'b1, 9'h030, 32'd0, 1'b0, lat);
        check("ldb_s_lat", 64'(lat), 64'd4);
        check("ldb_s_data", 64'(rsp_rdata), 64'hFFFFFF80);
        run_req(1'b0, 2'd0, 1'b0, 9'h030, 32'd0, 1'b0, lat);
        check("ldb_u_data", 64'(rsp_rdata), 64'h00000080);
        poke(9'h040, 8'h85); poke(9'h041, 8'h01);
        run_req(1'b0, 2'd1, 1'b1, 9'h040, 32'd0, 1'b0, lat);
        check("ldh_s_lat", 64'(lat), 64'd7);
        check("ldh_s_data", 64'(rsp_rdata), 64'hFFFF8501);

        poke(9'h1FE, 8'hA1); poke(9'h1FF, 8'hB2); poke(9'h000, 8'hC3); poke(9'h001, 8'hD4);
        rb = rcnt;
        run_req(1'b0, 2'd2, 1'b0, 9'h1FE, 32'd0, 1'b1, lat);
`ifdef CPU_LSU_ALIGN_CHECK_EN
        check("wrap_err", 64'(rsp_error), 64'd1);
        check("wrap_nrd", 64'(6'(rcnt - rb)), 64'd0);
        last_rdata = 32'd0;
        last_raddr = 9'h041;
`else
        check("wrap_lat", 64'(lat), 64'd33);
        check("wrap_data", 64'(rsp_rdata), 64'hA1B2C3D4);
        check("wrap_nrd", 64'(6'(rcnt - rb)), 64'd4);
        check("wrap_rd0", 64'(rl[rb]), 64'h1FE);
        check("wrap_rd1", 64'(rl[6'(rb + 6'd1)]), 64'h1FF);
        check("wrap_rd2", 64'(rl[6'(rb + 6'd2)]), 64'h000);
        check("wrap_rd3", 64'(rl[6'(rb + 6'd3)]), 64'h001);
        last_rdata = 32'hA1B2C3D4;
        last_raddr = 9'h001;
`endif

        rb = rcnt;
        wb = wcnt;
        run_req(1'b0, 2'd3, 1'b0, 9'h008, 32'd0, 1'b0, lat);
        check("szerr_lat", 64'(lat), 64'd1);
        check("szerr_err", 64'(rsp_error), 64'd1);
        check("szerr_rdata", 64'(rsp_rdata), 64'(last_rdata));
        check("szerr_raddr", 64'(mem_raddr), 64'(last_raddr));
        check("szerr_nrd", 64'(6'(rcnt - rb)), 64'd0);
        run_req(1'b1, 2'd3, 1'b0, 9'h008, 32'h01020304, 1'b0, lat);
        check("szerr_st_err", 64'(rsp_error), 64'd1);
        check("szerr_nwr", 64'(6'(wcnt - wb)), 64'd0);

        poke(9'h014, 8'h9A);
        run_req(1'b0, 2'd2, 1'b0, 9'h011, 32'd0, 1'b0, lat);
`ifdef CPU_LSU_ALIGN_CHECK_EN
        check("unal_lat", 64'(lat), 64'd1);
        check("unal_err", 64'(rsp_error), 64'd1);
        check("unal_data", 64'(rsp_rdata), 64'd0);
`else
        check("unal_lat", 64'(lat), 64'd13);
        check("unal_err", 64'(rsp_error), 64'd0);
        check("unal_data", 64'(rsp_rdata), 64'h3456789A);
`endif

        wb = wcnt;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 9'h050;
        req_wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_mid_mw_on", 64'(mem_write), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_mw_off", 64'(mem_write), 64'd0);
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("rst_mid_no_rsp", 64'(seen), 64'd0);
        check("rst_mid_ready2", 64'(req_ready), 64'd1);
        check("rst_mid_nwr", 64'(6'(wcnt - wb)), 64'd1);
        check("rst_mid_rdata", 64'(rsp_rdata), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
